// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-requester memory bus arbiter.
//   - default address / RAM line widths and timeout settings
//   - arbiter FSM state encoding (2 bits)
//   - small helper used to decide whether a requester is asking for the bus
package mem_bus_arbiter_pkg;

  localparam int C_ADDR_W        = 32;   // tag + index + offset
  localparam int C_RAM_DATA_SIZE = 128;  // one RAM line
  localparam int C_ARB_TIMEOUT   = 255;  // strobe cycles before a transfer is abandoned
  localparam int C_ARB_CNT_W     = 8;    // 2**C_ARB_CNT_W > C_ARB_TIMEOUT

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_ISSUE    = 2'd1,
    ARB_WAIT_ACK = 2'd2,
    ARB_RELEASE  = 2'd3
  } arb_state_t;

  // A requester wants the bus while either of its level requests is high.
  function automatic logic req_active(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Round-robin pick for two requesters (purely combinational).
//   req   : bit n high when requester n wants the bus
//   ptr   : requester that wins when both ask (0 or 1)
//   grant : one-hot winner, 00 when nobody asks
module arb_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one RAM port between two cache requesters.
//   REQn_RD/WR/ADDR/WDATA : level request from requester n, held until ACK or ERR
//   REQn_ACK / REQn_ERR   : one-cycle completion / timeout pulses to requester n
//   REQn_RDATA            : last line read on behalf of requester n
//   SIG_RAM_RD/WR, RAM_ADDR, RAM_WDATA, RAM_RDATA, MI_SIG_RAM_ACK : RAM side
//   GRANT                 : one-hot current owner, 00 when the bus is free
//   ARB_STATE             : FSM state, for observation only
//
// Handshake: a requester raises RD or WR and holds it; the arbiter latches
// address, data and operation at the grant edge, raises the RAM strobe for the
// following cycle and holds it until MI_SIG_RAM_ACK is sampled high (or the
// timeout expires). Completion is signalled by a one-cycle ACK (or ERR) pulse;
// the bus is only freed once the owner has dropped both RD and WR.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = C_ADDR_W,
  parameter int DATA_W  = C_RAM_DATA_SIZE,
  parameter int TIMEOUT = C_ARB_TIMEOUT,
  parameter int CNT_W   = C_ARB_CNT_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0_RD,
  input  logic              REQ0_WR,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [DATA_W-1:0] REQ0_WDATA,
  output logic              REQ0_ACK,
  output logic              REQ0_ERR,
  output logic [DATA_W-1:0] REQ0_RDATA,
  input  logic              REQ1_RD,
  input  logic              REQ1_WR,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [DATA_W-1:0] REQ1_WDATA,
  output logic              REQ1_ACK,
  output logic              REQ1_ERR,
  output logic [DATA_W-1:0] REQ1_RDATA,
  output logic              SIG_RAM_RD,
  output logic              SIG_RAM_WR,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA,
  input  logic              MI_SIG_RAM_ACK,
  output logic [1:0]        GRANT,
  output arb_state_t        ARB_STATE
);

  // The counter holds the number of strobe cycles already completed, so the
  // transfer is abandoned at the end of strobe cycle number TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_t       state, state_d;
  logic             ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       req;
  logic [1:0]       pick;
  logic             owner_active;
  logic             load;
  logic             done_ack;
  logic             done_err;
  logic             release_bus;

  assign req = {req_active(REQ1_RD, REQ1_WR), req_active(REQ0_RD, REQ0_WR)};
  assign owner_active = GRANT[1] ? req[1] : req[0];
  assign ARB_STATE = state;

  arb_rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick)
  );

  always_comb begin
    state_d     = state;
    load        = 1'b0;
    done_ack    = 1'b0;
    done_err    = 1'b0;
    release_bus = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (pick != 2'b00) begin
          load    = 1'b1;
          state_d = ARB_ISSUE;
        end
      end
      // The strobe is already up here; an acknowledge is only honoured from
      // WAIT_ACK onwards so every transfer sees at least two strobe cycles.
      ARB_ISSUE: begin
        state_d = ARB_WAIT_ACK;
      end
      // An ack on the last allowed cycle wins over the timeout.
      ARB_WAIT_ACK: begin
        if (MI_SIG_RAM_ACK) begin
          done_ack = 1'b1;
          state_d  = ARB_RELEASE;
        end else if (cnt >= CNT_LAST) begin
          done_err = 1'b1;
          state_d  = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        if (!owner_active) begin
          release_bus = 1'b1;
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ARB_IDLE;
      ptr        <= 1'b0;
      cnt        <= '0;
      GRANT      <= 2'b00;
      SIG_RAM_RD <= 1'b0;
      SIG_RAM_WR <= 1'b0;
      RAM_ADDR   <= '0;
      RAM_WDATA  <= '0;
      REQ0_ACK   <= 1'b0;
      REQ0_ERR   <= 1'b0;
      REQ0_RDATA <= '0;
      REQ1_ACK   <= 1'b0;
      REQ1_ERR   <= 1'b0;
      REQ1_RDATA <= '0;
    end else begin
      state    <= state_d;
      REQ0_ACK <= 1'b0;
      REQ0_ERR <= 1'b0;
      REQ1_ACK <= 1'b0;
      REQ1_ERR <= 1'b0;

      if ((state == ARB_ISSUE || state == ARB_WAIT_ACK) && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end

      // Everything the RAM sees is captured at the grant edge; a write wins
      // when a requester raises RD and WR together.
      if (load) begin
        GRANT <= pick;
        cnt   <= '0;
        if (pick[1]) begin
          RAM_ADDR   <= REQ1_ADDR;
          RAM_WDATA  <= REQ1_WDATA;
          SIG_RAM_WR <= REQ1_WR;
          SIG_RAM_RD <= ~REQ1_WR;
        end else begin
          RAM_ADDR   <= REQ0_ADDR;
          RAM_WDATA  <= REQ0_WDATA;
          SIG_RAM_WR <= REQ0_WR;
          SIG_RAM_RD <= ~REQ0_WR;
        end
      end

      if (done_ack || done_err) begin
        SIG_RAM_RD <= 1'b0;
        SIG_RAM_WR <= 1'b0;
      end

      // SIG_RAM_RD is still high on the ack edge, so it tells reads from writes.
      if (done_ack) begin
        if (GRANT[1]) begin
          REQ1_ACK <= 1'b1;
          if (SIG_RAM_RD) REQ1_RDATA <= RAM_RDATA;
        end else begin
          REQ0_ACK <= 1'b1;
          if (SIG_RAM_RD) REQ0_RDATA <= RAM_RDATA;
        end
      end

      if (done_err) begin
        if (GRANT[1]) REQ1_ERR <= 1'b1;
        else          REQ0_ERR <= 1'b1;
      end

      // Priority passes to the requester that did not just own the bus.
      if (release_bus) begin
        GRANT <= 2'b00;
        ptr   <= GRANT[0];
      end
    end
  end

endmodule
